stream_fifo_chan: RTL and testbench
===================================

Name: stream_fifo_chan

Overview:
- Point-to-point stream channel between dataflow cells of the insertion-sort pipeline.
- Upstream cell's writer port (din/full_n/write) drives the write side; downstream cell's reader port (dout/empty_n/read) drives the read side.
- First-word-fall-through circular buffer with registered status flags.
- Responder for both ends of the FIFO handshake the sort cells initiate.

Parameters:
- DATA_WIDTH, 32, bit width of each stream word (signed payload; treated as opaque bits).
- DEPTH, 2, number of storage entries. Legal range 2..1024; need not be a power of two.
- ADDR_WIDTH, 1, pointer width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- if_din  in  DATA_WIDTH  write data from upstream cell.
- if_full_n  out  1  1 = space available; write accepted this cycle if if_write=1.
- if_write  in  1  upstream write strobe.
- if_dout  out  DATA_WIDTH  head-of-queue word; valid while if_empty_n=1.
- if_empty_n  out  1  1 = data available; head popped this cycle if if_read=1.
- if_read  in  1  downstream read strobe.
- if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- State: mem[DEPTH], wr_ptr, rd_ptr (ADDR_WIDTH), count (ADDR_WIDTH+1), registered empty_n_r and full_n_r.
- push = if_write & full_n_r. pop = if_read & empty_n_r.
- Write/read strobes with the corresponding flag low are ignored: no state change, no error.
- push: mem[wr_ptr] <= if_din; wr_ptr advances. Wrap: DEPTH-1 -> 0 by explicit compare, not modulo-2**ADDR_WIDTH.
- pop: rd_ptr advances with the same wrap rule.
- count update:
  - push & ~pop: +1
  - pop & ~push: -1
  - both or neither: unchanged
- Flags are registered from next-count:
  - full_n_r <= (next_count != DEPTH)
  - empty_n_r <= (next_count != 0)
  - if_full_n and if_empty_n drive the registers directly; no combinational path from if_write/if_read to any flag.
- Latency:
  - Word pushed into an empty FIFO at edge N: if_empty_n=1 and if_dout=that word in the cycle after edge N (1-cycle write-to-read).
  - Pop at edge N: if_dout shows the next entry in the cycle after edge N (no bubble when count>=2).
  - Freed slot: if_full_n rises in the cycle after the pop edge.
- if_dout = mem[rd_ptr] when empty_n_r=1, else all zeros. Forced to 0 when empty; never X at the output.
- Simultaneous push & pop:
  - 0<count<DEPTH: both succeed, count unchanged, data order preserved.
  - count==DEPTH: full_n=0, so only pop succeeds; count -> DEPTH-1.
  - count==0: empty_n=0, so only push succeeds; count -> 1.
- Ordering: strict FIFO, no reordering or duplication. Each word is delivered exactly once.
- Reset (ap_rst=1 at rising edge), taking effect after that edge:
  - wr_ptr=rd_ptr=0, count=0, empty_n=0, full_n=1, if_dout=0.
  - Memory contents are not cleared; they are unobservable because if_dout is gated.
  - Reset overrides any simultaneous push/pop.
  - Reset mid-stream discards all stored words.
- Outputs during the cycle ap_rst is first sampled hold the prior values. No asynchronous behaviour.
- if_count = count register (registered, same-cycle consistent with the flags).

Test Plan:
- Reset then idle:
  - assert ap_rst 2 cycles, release -> if_empty_n=0, if_full_n=1, if_count=0, if_dout=0.
  - Reads while empty are ignored; if_count stays 0.
- Single word, DEPTH=2:
  - write 0x0000002A at edge 1 -> cycle after: if_empty_n=1, if_dout=0x2A, if_count=1.
  - read at edge 2 -> if_empty_n=0, if_dout=0.
- Fill to full, DEPTH=2:
  - write 0x11, 0x22 on consecutive edges -> if_full_n=0, if_count=2.
  - third write of 0x33 is ignored.
  - two reads return 0x11 then 0x22; if_full_n=1 after the first pop.
- Simultaneous push/pop:
  - count=1 (head 0x05): write 0xFFFFFFFB and read at the same edge -> count stays 1, if_dout=0xFFFFFFFB.
  - count=2, both strobes: only the pop happens, count=1.
- Wrap-around, DEPTH=3, ADDR_WIDTH=2:
  - stream 10 words 1..10 with random read/write stalls -> output sequence exactly 1..10.
  - pointers never reach index 3; if_count never exceeds 3.
- Reset mid-operation:
  - with count=2, assert ap_rst for one edge while also asserting if_write -> next cycle count=0, empty_n=0, full_n=1.
  - subsequent write 0x7 is read back as 0x7 (no stale data).

Source files
------------

// File: rtl/stream_fifo_chan.sv
// First-word-fall-through stream FIFO joining two dataflow cells.
// Status flags and occupancy are registered; the head word is gated to zero while empty.
module stream_fifo_chan #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_write,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_full_n;
    logic                  r_empty_n;

    logic                  w_push;
    logic                  w_pop;
    logic [CNT_WIDTH-1:0]  w_count_nxt;

    // Pointer wrap compares against DEPTH-1 so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] f_next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign w_push = if_write & r_full_n;
    assign w_pop  = if_read  & r_empty_n;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
            2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and flags; flags are derived from next occupancy.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            r_count   <= w_count_nxt;
            r_full_n  <= (w_count_nxt != DEPTH_CNT);
            r_empty_n <= (w_count_nxt != '0);
        end
    end

    // Storage is not cleared on reset; stale words are hidden by the output gate.
    always_ff @(posedge ap_clk) begin
        if (w_push && !ap_rst) r_mem[r_wr_ptr] <= if_din;
    end

    assign if_dout    = r_empty_n ? r_mem[r_rd_ptr] : '0;
    assign if_full_n  = r_full_n;
    assign if_empty_n = r_empty_n;
    assign if_count   = r_count;

endmodule

// File: tb/tb_stream_fifo_chan.sv
// Bench for stream_fifo_chan: directed DEPTH=2 steps plus a randomized DEPTH=3 wrap stream,
// both compared against a queue-based model of the channel.
module tb_stream_fifo_chan;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;

    logic [31:0] a_din = '0;
    logic        a_write = 1'b0, a_read = 1'b0;
    logic [31:0] a_dout;
    logic        a_full_n, a_empty_n;
    logic [1:0]  a_count;

    logic [31:0] b_din = '0;
    logic        b_write = 1'b0, b_read = 1'b0;
    logic [31:0] b_dout;
    logic        b_full_n, b_empty_n;
    logic [2:0]  b_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] outb[$];
    int          b_pushed;

    always #5 ap_clk = ~ap_clk;

    stream_fifo_chan #(.DATA_WIDTH(32), .DEPTH(2), .ADDR_WIDTH(1)) dut_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .if_din(a_din), .if_full_n(a_full_n), .if_write(a_write),
        .if_dout(a_dout), .if_empty_n(a_empty_n), .if_read(a_read),
        .if_count(a_count)
    );

    stream_fifo_chan #(.DATA_WIDTH(32), .DEPTH(3), .ADDR_WIDTH(2)) dut_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .if_din(b_din), .if_full_n(b_full_n), .if_write(b_write),
        .if_dout(b_dout), .if_empty_n(b_empty_n), .if_read(b_read),
        .if_count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Visible state of a channel holding queue q with capacity d.
    task automatic chk_chan(input string tag, input logic [31:0] q[$], input int d,
                            input logic [31:0] dout, input logic empty_n,
                            input logic full_n, input logic [31:0] count);
        chk({tag, ".count"},   count,                 32'(q.size()));
        chk({tag, ".empty_n"}, 32'(empty_n),          32'(q.size() != 0));
        chk({tag, ".full_n"},  32'(full_n),           32'(q.size() != d));
        chk({tag, ".dout"},    dout,                  (q.size() != 0) ? q[0] : 32'h0);
    endtask

    // One clock edge on both channels; the model decides acceptance from pre-edge occupancy.
    task automatic step(input logic rst,
                        input logic wa, input logic ra, input logic [31:0] da,
                        input logic wb, input logic rb, input logic [31:0] db);
        bit pa, oa, pb, ob;
        ap_rst = rst;
        a_write = wa; a_read = ra; a_din = da;
        b_write = wb; b_read = rb; b_din = db;
        pa = wa && qa.size() < 2;
        oa = ra && qa.size() > 0;
        pb = wb && qb.size() < 3;
        ob = rb && qb.size() > 0;
        @(posedge ap_clk);
        #1;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (oa) void'(qa.pop_front());
            if (pa) qa.push_back(da);
            if (ob) outb.push_back(qb.pop_front());
            if (pb) begin
                qb.push_back(db);
                b_pushed++;
            end
        end
        ap_rst = 1'b0;
        a_write = 1'b0; a_read = 1'b0;
        b_write = 1'b0; b_read = 1'b0;
        chk_chan("A", qa, 2, a_dout, a_empty_n, a_full_n, 32'(a_count));
        chk_chan("B", qb, 3, b_dout, b_empty_n, b_full_n, 32'(b_count));
    endtask

    task automatic sa(input logic wa, input logic ra, input logic [31:0] da);
        step(1'b0, wa, ra, da, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int budget;
        b_pushed = 0;

        // Reset for two cycles, then idle and reads on empty.
        step(1'b1, 0, 0, '0, 0, 0, '0);
        step(1'b1, 0, 0, '0, 0, 0, '0);
        chk("rst.dout_zero", a_dout, 32'h0);
        chk("rst.full_n", 32'(a_full_n), 32'h1);
        sa(0, 1, '0);
        sa(0, 1, '0);
        chk("empty_read.count", 32'(a_count), 32'h0);

        // Single word, and write+read on empty (only the push lands).
        sa(1, 0, 32'h0000002A);
        chk("single.dout", a_dout, 32'h2A);
        sa(0, 1, '0);
        chk("single.drained", 32'(a_empty_n), 32'h0);
        sa(1, 1, 32'h0000002B);
        chk("empty_wr_rd.count", 32'(a_count), 32'h1);
        sa(0, 1, '0);

        // Fill to full, third write ignored, drain in order.
        sa(1, 0, 32'h11);
        sa(1, 0, 32'h22);
        chk("full.full_n", 32'(a_full_n), 32'h0);
        sa(1, 0, 32'h33);
        sa(0, 1, '0);
        chk("full.second_head", a_dout, 32'h22);
        chk("full.full_n_rise", 32'(a_full_n), 32'h1);
        sa(0, 1, '0);

        // Simultaneous push/pop at count 1, then at count 2.
        sa(1, 0, 32'h05);
        sa(1, 1, 32'hFFFFFFFB);
        chk("simul1.dout", a_dout, 32'hFFFFFFFB);
        sa(1, 0, 32'h06);
        sa(1, 1, 32'h07);
        chk("simul2.count", 32'(a_count), 32'h1);
        chk("simul2.head", a_dout, 32'h06);
        sa(0, 1, '0);

        // Reset mid-stream with a concurrent write.
        sa(1, 0, 32'hA1);
        sa(1, 0, 32'hA2);
        step(1'b1, 1, 0, 32'hA3, 0, 0, '0);
        chk("midrst.count", 32'(a_count), 32'h0);
        sa(1, 0, 32'h7);
        chk("midrst.fresh", a_dout, 32'h7);
        sa(0, 1, '0);

        // Random stalls on the DEPTH=3 channel streaming 1..10.
        budget = 400;
        while (outb.size() < 10 && budget > 0) begin
            logic wb, rb;
            wb = (b_pushed < 10) && ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 2) == 0);
            step(1'b0, 0, 0, '0, wb, rb, 32'(b_pushed + 1));
            chk("wrap.count_bound", 32'(b_count <= 3'd3), 32'h1);
            budget--;
        end
        chk("wrap.delivered", 32'(outb.size()), 32'd10);
        for (int i = 0; i < outb.size(); i++)
            chk($sformatf("wrap.word%0d", i), outb[i], 32'(i + 1));
        step(1'b0, 0, 1, '0, 0, 1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
